// File: rtl/alu_share_arbiter.sv
// Shared-ALU arbiter: two requesters take turns on one external alu through a
// req/done handshake; operands are latched at grant and the result is registered.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module alu_share_arbiter
  import cpu_types_pkg::*;
(
  input  logic   CLK,
  input  logic   RST,
  input  logic   req0,
  input  logic   req1,
  input  word_t  a0,
  input  word_t  b0,
  input  aluop_t op0,
  input  word_t  a1,
  input  word_t  b1,
  input  aluop_t op1,
  output logic   gnt0,
  output logic   gnt1,
  output logic   done0,
  output logic   done1,
  output word_t  result,
  output logic   neg,
  output logic   overflow,
  output logic   zero,
  output logic   busy,
  output word_t  alu_A,
  output word_t  alu_B,
  output aluop_t alu_op,
  input  word_t  alu_result,
  input  logic   alu_neg,
  input  logic   alu_overflow,
  input  logic   alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   sel, last, pick, take;
  word_t  opa, opb;
  aluop_t opc;

  // A tie goes to whichever requester was not served last.
  always_comb begin
    pick = (req0 && req1) ? ~last : req1;
    take = (state == IDLE) && (req0 || req1);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0 || req1) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    gnt0  = busy && !sel;
    gnt1  = busy &&  sel;
    done0 = (state == RESP) && !sel;
    done1 = (state == RESP) &&  sel;
  end

  // Operands are captured once at grant so late requester changes cannot leak in.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel      <= 1'b0;
      last     <= 1'b1;
      opa      <= '0;
      opb      <= '0;
      opc      <= ALU_ADD;
      result   <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      if (take) begin
        sel <= pick;
        opa <= pick ? a1  : a0;
        opb <= pick ? b1  : b0;
        opc <= pick ? op1 : op0;
      end
      if (state == EXEC) begin
        result   <= alu_result;
        neg      <= alu_neg;
        overflow <= alu_overflow;
        zero     <= alu_zero;
        last     <= sel;
      end
    end
  end

  // The alu always sees the latched operands, so its inputs never glitch between ops.
  assign alu_A  = opa;
  assign alu_B  = opb;
  assign alu_op = opc;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural alu, time-based transaction model,
// directed test-plan steps followed by a randomized handshake phase.
module tb_alu_share_arbiter;
  import cpu_types_pkg::*;

  typedef struct packed {
    word_t r;
    logic  n;
    logic  v;
    logic  z;
  } alu_out_t;

  logic   CLK = 1'b0;
  logic   RST = 1'b1;
  logic   req0 = 1'b0, req1 = 1'b0;
  word_t  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  aluop_t op0 = ALU_ADD, op1 = ALU_ADD;
  logic   gnt0, gnt1, done0, done1, neg, overflow, zero, busy;
  word_t  result, alu_A, alu_B, alu_result;
  aluop_t alu_op;
  logic   alu_neg, alu_overflow, alu_zero;

  always #5 CLK = ~CLK;

  alu_share_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .op0(op0),
    .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .neg(neg), .overflow(overflow), .zero(zero),
    .busy(busy),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_result(alu_result), .alu_neg(alu_neg),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero)
  );

  function automatic alu_out_t alu_ref(input word_t a, input word_t b, input aluop_t op);
    alu_out_t o;
    o = '0;
    case (op)
      ALU_ADD: begin
        o.r = a + b;
        o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      ALU_SUB: begin
        o.r = a - b;
        o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      ALU_AND:  o.r = a & b;
      ALU_OR:   o.r = a | b;
      ALU_XOR:  o.r = a ^ b;
      ALU_SLL:  o.r = a << b[4:0];
      ALU_SRL:  o.r = a >> b[4:0];
      ALU_SRA:  o.r = word_t'($signed(a) >>> b[4:0]);
      ALU_SLT:  o.r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: o.r = {31'd0, a < b};
      default:  o.r = '0;
    endcase
    o.n = o.r[31];
    o.z = (o.r == '0);
    return o;
  endfunction

  // The shared alu itself lives in the bench.
  alu_out_t ao;
  always_comb begin
    ao = alu_ref(alu_A, alu_B, alu_op);
  end
  assign alu_result   = ao.r;
  assign alu_neg      = ao.n;
  assign alu_overflow = ao.v;
  assign alu_zero     = ao.z;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction model: a grant at edge k owns the alu through edge k+1 (done after
  // k+1), and the arbiter can sample again at edge k+3.
  logic     m_active = 1'b0;
  int       m_start = 0, m_free = 0, m_sel = 0, m_last = 1;
  word_t    m_a = '0, m_b = '0;
  aluop_t   m_op = ALU_ADD;
  alu_out_t m_out = '0;
  logic     ed0, ed1, eg0, eg1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (RST) begin
      m_active = 1'b0;
      m_last   = 1;
      m_out    = '0;
      m_a      = '0;
      m_b      = '0;
      m_op     = ALU_ADD;
      m_free   = cyc + 1;
    end else begin
      if (m_active && cyc == m_start + 1) begin
        m_out  = alu_ref(m_a, m_b, m_op);
        m_last = m_sel;
      end
      if (cyc >= m_free && (req0 || req1)) begin
        m_sel    = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
        m_a      = m_sel ? a1  : a0;
        m_b      = m_sel ? b1  : b0;
        m_op     = m_sel ? op1 : op0;
        m_start  = cyc;
        m_free   = cyc + 3;
        m_active = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic own, dn;
    own = m_active && cyc >= m_start && cyc <= m_start + 1;
    dn  = m_active && cyc == m_start + 1;
    eg0 = own && m_sel == 0;
    eg1 = own && m_sel == 1;
    ed0 = dn && m_sel == 0;
    ed1 = dn && m_sel == 1;
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("done0", done0, ed0);
    chk("done1", done1, ed1);
    chk("busy", busy, own);
    chk("result", result, m_out.r);
    chk("flags", {neg, overflow, zero}, {m_out.n, m_out.v, m_out.z});
    chk("alu_A", alu_A, m_a);
    chk("alu_B", alu_B, m_b);
    chk("alu_op", alu_op, m_op);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
    cyc++;
  endtask

  // Steps until the model expects done for requester r; a missed bound is a failure.
  task automatic serve(input int r);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      step();
      hit = (r == 0) ? ed0 : ed1;
    end
    chk($sformatf("serve%0d_timeout", r), hit, 1'b1);
  endtask

  function automatic word_t rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset then idle.
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    repeat (5) step();
    chk("idle_result", result, 32'h0);
    chk("idle_busy", busy, 1'b0);

    // Single add.
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = ALU_ADD;
    step();
    chk("add_gnt0", gnt0, 1'b1);
    step();
    chk("add_done0", done0, 1'b1);
    chk("add_result", result, 32'd8);
    chk("add_flags", {neg, overflow, zero}, 3'b000);
    req0 = 1'b0;
    step(); step();

    // Flag paths on requester 1.
    req1 = 1'b1; a1 = 32'd3; b1 = 32'd5; op1 = ALU_SUB;
    serve(1);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_neg", neg, 1'b1);
    a1 = 32'h7FFF_FFFF; b1 = 32'd1; op1 = ALU_ADD;
    serve(1);
    chk("ovf_result", result, 32'h8000_0000);
    chk("ovf_flags", {neg, overflow}, 2'b11);
    a1 = 32'd7; b1 = 32'd7; op1 = ALU_SUB;
    serve(1);
    chk("zero_flag", zero, 1'b1);
    req1 = 1'b0;
    step(); step();

    // Contention: both held, grants alternate starting with requester 0.
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd1; op0 = ALU_ADD;
    req1 = 1'b1; a1 = 32'd2; b1 = 32'd2; op1 = ALU_ADD;
    step();
    chk("cont_gnt0_first", gnt0, 1'b1);
    step();
    chk("cont_done0", done0, 1'b1);
    chk("cont_result0", result, 32'd2);
    step(); step(); step();
    chk("cont_done1", done1, 1'b1);
    chk("cont_result1", result, 32'd4);
    serve(0);
    serve(1);
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // Operand stability: a0 changes while the op is in EXEC.
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = ALU_ADD;
    step();
    a0 = 32'd9;
    step();
    chk("stab_old", result, 32'd8);
    serve(0);
    chk("stab_new", result, 32'd12);
    req0 = 1'b0;
    step(); step();

    // Reset mid-op of requester 1, then a tie goes to requester 0.
    req1 = 1'b1; a1 = 32'd40; b1 = 32'd2; op1 = ALU_ADD;
    step();
    chk("rst_gnt1", gnt1, 1'b1);
    RST = 1'b1;
    step();
    chk("rst_no_done1", done1, 1'b0);
    chk("rst_result", result, 32'h0);
    RST = 1'b0;
    req0 = 1'b1; a0 = 32'd6; b0 = 32'd6; op0 = ALU_SUB;
    step();
    chk("rst_tie_gnt0", gnt0, 1'b1);
    step();
    chk("rst_tie_zero", zero, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // Randomized handshake traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      RST = ($urandom_range(0, 79) == 0);
      if (!req0) begin
        if ($urandom_range(0, 2) == 0) begin
          req0 = 1'b1; a0 = rnd_word(); b0 = rnd_word();
          op0 = aluop_t'($urandom_range(0, 9));
        end
      end else if (ed0) begin
        if ($urandom_range(0, 1) == 0) req0 = 1'b0;
        else begin
          a0 = rnd_word(); b0 = rnd_word(); op0 = aluop_t'($urandom_range(0, 9));
        end
      end else if (eg0 && $urandom_range(0, 5) == 0) begin
        req0 = 1'b0;
      end
      if (!req1) begin
        if ($urandom_range(0, 2) == 0) begin
          req1 = 1'b1; a1 = rnd_word(); b1 = rnd_word();
          op1 = aluop_t'($urandom_range(0, 9));
        end
      end else if (ed1) begin
        if ($urandom_range(0, 1) == 0) req1 = 1'b0;
        else begin
          a1 = rnd_word(); b1 = rnd_word(); op1 = aluop_t'($urandom_range(0, 9));
        end
      end else if (eg1 && $urandom_range(0, 5) == 0) begin
        req1 = 1'b0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
